// File: rtl/audio_sample_pio.sv
// Multi-channel audio capture port: frames sampled on in_valid are queued in a FIFO
// and read back by the HPS through a small Avalon-MM register map with 1-cycle read latency.
module audio_sample_pio #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned CHANNELS   = 2,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter bit          SIGN_EXT   = 1'b1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [CHANNELS*DATA_W-1:0]   in_port,
    input  logic                         in_valid,
    input  logic [2:0]                   address,
    input  logic                         write,
    input  logic [31:0]                  writedata,
    output logic [31:0]                  readdata,
    output logic                         irq
);

    localparam int unsigned FrameW = CHANNELS * DATA_W;
    localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW   = PtrW + 1;

    localparam logic [2:0] AddrStatus  = 3'd0;
    localparam logic [2:0] AddrControl = 3'd1;
    localparam logic [2:0] AddrLive    = 3'd2;
    localparam logic [2:0] AddrPop     = 3'd3;

    logic [FrameW-1:0] mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]   count_q;
    logic              ovf_q, en_q, irq_en_q;
    logic [7:0]        thr_q;
    logic [31:0]       readdata_q, readdata_d;
    logic              irq_q, irq_d;

    logic wr_status, wr_control, wr_pop, flush;
    logic full, empty, pop_ok, capture, push, pop, ovf_set, ovf_clr;
    logic [7:0] thr_eff;
    logic unused_wdata;

    function automatic logic [31:0] extend(input logic [DATA_W-1:0] s);
        if (SIGN_EXT) begin
            return 32'($signed(s));
        end
        return 32'(s);
    endfunction

    assign wr_status  = write && (address == AddrStatus);
    assign wr_control = write && (address == AddrControl);
    assign wr_pop     = write && (address == AddrPop);
    assign flush      = wr_control & writedata[2];
    assign ovf_clr    = wr_status & writedata[18];

    assign full    = (count_q == CntW'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    assign pop_ok  = wr_pop & ~empty;
    assign capture = in_valid & en_q;
    // A pop in the same cycle frees a slot, so a push at full is still accepted.
    assign push    = capture & (~full | pop_ok) & ~flush;
    assign pop     = pop_ok & ~flush;
    assign ovf_set = capture & full & ~pop_ok;

    assign unused_wdata = ^{writedata[31:19], writedata[17:16], writedata[7:3]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            en_q     <= 1'b0;
            irq_en_q <= 1'b0;
            thr_q    <= '0;
        end else begin
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
                if (push && !pop) begin
                    count_q <= count_q + CntW'(1);
                end else if (pop && !push) begin
                    count_q <= count_q - CntW'(1);
                end
            end
            ovf_q <= ovf_set | (ovf_q & ~ovf_clr);
            if (wr_control) begin
                en_q     <= writedata[0];
                irq_en_q <= writedata[1];
                thr_q    <= writedata[15:8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_port;
        end
    end

    always_comb begin
        readdata_d = '0;
        case (address)
            AddrStatus:  readdata_d = {13'b0, ovf_q, full, empty, 7'b0, 9'(count_q)};
            AddrControl: readdata_d = {16'b0, thr_q, 5'b0, 1'b0, irq_en_q, en_q};
            AddrLive:    readdata_d = extend(in_port[DATA_W-1:0]);
            AddrPop:     readdata_d = '0;
            default: begin
                for (int c = 0; c < int'(CHANNELS); c++) begin
                    if (address == 3'(4 + c) && !empty) begin
                        readdata_d = extend(mem_q[rd_ptr_q][c*DATA_W +: DATA_W]);
                    end
                end
            end
        endcase
    end

    // A threshold of 0 behaves as 1 so an empty FIFO never raises irq.
    assign thr_eff = (thr_q == 8'd0) ? 8'd1 : thr_q;
    assign irq_d   = irq_en_q & (ovf_q | (9'(count_q) >= {1'b0, thr_eff}));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_audio_sample_pio.sv
// Bench for audio_sample_pio (DATA_W=16, CHANNELS=2, FIFO_DEPTH=16, SIGN_EXT=1):
// directed vector tables, hand sequences, then random traffic against a queue model.
module tb_audio_sample_pio;

    localparam int D = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] in_port;
    logic        in_valid;
    logic [2:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [2:0]  addr;
        logic [31:0] exp;
        string       name;
    } vec_t;
    vec_t vecs[$];

    // reference model state
    logic [31:0] mq[$];
    bit          m_ovf, m_en, m_ie;
    logic [7:0]  m_thr;

    audio_sample_pio #(
        .DATA_W    (16),
        .CHANNELS  (2),
        .FIFO_DEPTH(D),
        .SIGN_EXT  (1'b1)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_port  (in_port),
        .in_valid (in_valid),
        .address  (address),
        .write    (write),
        .writedata(writedata),
        .readdata (readdata),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        address  = a;
        write    = 1'b0;
        in_valid = 1'b0;
        tick();
        d = readdata;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address   = a;
        write     = 1'b1;
        writedata = d;
        tick();
        write = 1'b0;
    endtask

    task automatic push(input logic [31:0] f);
        in_port  = f;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic add(input logic [2:0] a, input logic [31:0] e, input string n);
        vec_t v;
        v.addr = a;
        v.exp  = e;
        v.name = n;
        vecs.push_back(v);
    endtask

    task automatic run_table();
        logic [31:0] d;
        foreach (vecs[i]) begin
            rd(vecs[i].addr, d);
            check(vecs[i].name, d, vecs[i].exp);
        end
        vecs.delete();
    endtask

    function automatic logic [31:0] sx(input logic [15:0] s);
        return {{16{s[15]}}, s};
    endfunction

    function automatic logic [31:0] model_read(input logic [2:0] a, input logic [31:0] ip);
        int n;
        n = mq.size();
        case (a)
            3'd0: return 32'(n) | ((n == 0) ? 32'h1_0000 : 0) | ((n == D) ? 32'h2_0000 : 0)
                         | (m_ovf ? 32'h4_0000 : 0);
            3'd1: return {16'b0, m_thr, 6'b0, m_ie, m_en};
            3'd2: return sx(ip[15:0]);
            3'd4: return (n == 0) ? 32'h0 : sx(mq[0][15:0]);
            3'd5: return (n == 0) ? 32'h0 : sx(mq[0][31:16]);
            default: return 32'h0;
        endcase
    endfunction

    initial begin
        logic [31:0] d;
        reset_n   = 1'b0;
        in_port   = '0;
        in_valid  = 1'b0;
        address   = '0;
        write     = 1'b0;
        writedata = '0;
        repeat (3) tick();
        check("reset_irq", {31'b0, irq}, 32'h0);
        reset_n = 1'b1;
        tick();

        for (int a = 0; a < 8; a++) begin
            add(3'(a), (a == 0) ? 32'h0001_0000 : 32'h0, $sformatf("reset_rd%0d", a));
        end
        run_table();
        check("reset_irq_after", {31'b0, irq}, 32'h0);

        // single frame, sign extension, pop to empty
        wr(3'd1, 32'h1);
        push(32'h7FFF_8001);
        add(3'd4, 32'hFFFF_8001, "head_ch0");
        add(3'd5, 32'h0000_7FFF, "head_ch1");
        add(3'd0, 32'h0000_0001, "status_one");
        add(3'd2, 32'hFFFF_8001, "live");
        add(3'd1, 32'h0000_0001, "control");
        add(3'd3, 32'h0000_0000, "pop_reads0");
        run_table();
        wr(3'd3, 32'h0);
        add(3'd0, 32'h0001_0000, "status_popped");
        add(3'd4, 32'h0, "head_empty0");
        add(3'd5, 32'h0, "head_empty1");
        run_table();

        // fill, overflow, W1C
        for (int i = 0; i < D; i++) push({16'(32'h100 + i), 16'(i)});
        rd(3'd0, d); check("status_full", d, 32'h0002_0010);
        push(32'h0000_0055);
        rd(3'd0, d); check("status_ovf", d, 32'h0006_0010);
        rd(3'd5, d); check("head_after_ovf", d, 32'h0000_0100);
        wr(3'd0, 32'h0004_0000);
        rd(3'd0, d); check("status_w1c", d, 32'h0002_0010);

        // push and pop together at full
        address   = 3'd3;
        write     = 1'b1;
        writedata = '0;
        in_port   = 32'h0177_0077;
        in_valid  = 1'b1;
        tick();
        write    = 1'b0;
        in_valid = 1'b0;
        rd(3'd0, d); check("status_pushpop", d, 32'h0002_0010);
        for (int k = 0; k < D; k++) begin
            rd(3'd4, d);
            check($sformatf("drain%0d", k), d, (k < D - 1) ? 32'(k + 1) : 32'h77);
            wr(3'd3, 32'h0);
        end
        rd(3'd0, d); check("status_drained", d, 32'h0001_0000);

        // threshold irq timing and flush
        wr(3'd1, 32'h0000_0403);
        for (int i = 0; i < 3; i++) push(32'(i));
        check("irq_below", {31'b0, irq}, 32'h0);
        push(32'h3);
        check("irq_lag", {31'b0, irq}, 32'h0);
        tick();
        check("irq_rise", {31'b0, irq}, 32'h1);
        wr(3'd3, 32'h0);
        check("irq_hold", {31'b0, irq}, 32'h1);
        tick();
        check("irq_fall", {31'b0, irq}, 32'h0);
        for (int i = 0; i < 5; i++) push(32'(i));
        tick();
        check("irq_eight", {31'b0, irq}, 32'h1);
        wr(3'd1, 32'h0000_0407);
        rd(3'd0, d); check("status_flush", d, 32'h0001_0000);
        check("irq_flush", {31'b0, irq}, 32'h0);
        rd(3'd1, d); check("control_flush", d, 32'h0000_0403);

        // asynchronous reset mid-burst
        for (int i = 0; i < 5; i++) push(32'(i));
        address  = 3'd0;
        in_valid = 1'b1;
        tick();
        check("pre_reset_status", readdata, 32'h0000_0005);
        #2 reset_n = 1'b0;
        #1;
        check("async_rd", readdata, 32'h0);
        check("async_irq", {31'b0, irq}, 32'h0);
        in_valid = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        rd(3'd0, d); check("post_reset_status", d, 32'h0001_0000);
        rd(3'd1, d); check("post_reset_control", d, 32'h0);

        // random traffic against the queue model
        mq.delete();
        m_ovf = 0; m_en = 0; m_ie = 0; m_thr = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic [31:0] exp_rd, wd, ip;
            logic [2:0]  a;
            bit          wr_en, iv, flush, popv, cap, clr, set;
            int          op, pre;
            logic        exp_irq;
            ip    = $urandom;
            iv    = ($urandom_range(0, 2) != 0);
            op    = $urandom_range(0, 15);
            wr_en = 1'b1;
            wd    = $urandom;
            if (op < 4) begin
                a = 3'd3;
            end else if (op == 4) begin
                a = 3'd0;
            end else if (op == 5) begin
                a  = 3'd1;
                wd = {16'b0, 8'($urandom_range(0, 20)), 5'b0,
                      1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 3) != 0)};
            end else begin
                a     = 3'($urandom_range(0, 7));
                wr_en = 1'b0;
            end
            exp_rd  = model_read(a, ip);
            exp_irq = m_ie & (m_ovf | (mq.size() >= ((m_thr == 0) ? 1 : int'(m_thr))));

            address   = a;
            write     = wr_en;
            writedata = wd;
            in_port   = ip;
            in_valid  = iv;
            tick();
            check($sformatf("rand_rd%0d", cyc), readdata, exp_rd);
            check($sformatf("rand_irq%0d", cyc), {31'b0, irq}, {31'b0, exp_irq});

            pre   = mq.size();
            flush = wr_en && a == 3'd1 && wd[2];
            popv  = wr_en && a == 3'd3 && pre > 0;
            cap   = iv && m_en;
            set   = cap && pre == D && !popv;
            clr   = wr_en && a == 3'd0 && wd[18];
            if (flush) begin
                mq.delete();
            end else begin
                if (popv) void'(mq.pop_front());
                if (cap && (pre < D || popv)) mq.push_back(ip);
            end
            m_ovf = set | (m_ovf & !clr);
            if (wr_en && a == 3'd1) begin
                m_en  = wd[0];
                m_ie  = wd[1];
                m_thr = wd[15:8];
            end
        end
        write    = 1'b0;
        in_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
